dac_spi_writer: RTL and testbench

//  Receiving end of the threshold DAC interface driven by the channel measure controller.
//  - Accepts a 16-bit threshold word on a write strobe and serializes it as one SPI frame
//    (AD5683-style) to the comparator-reference DAC.
//  - Holds threshold_rdy_o low until the frame is shifted and the DAC settle time has elapsed,
//    so the controller only samples the comparator against a settled threshold.

---
 rtl/dac_pkg.sv | 33 +++
 rtl/spi_tick_gen.sv | 39 +++
 rtl/dac_spi_writer.sv | 209 ++++++++++++++++++++
 tb/tb_dac_spi_writer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// ---------------------------------------------------------------------------
// dac_pkg
//   Shared definitions for the threshold DAC SPI writer:
//   - dac_state_t      : serializer FSM states
//   - FRAME_W          : SPI frame length in bits
//   - CODE_W           : threshold code width
//   - BIT_CNT_W        : width of the frame bit counter
//   - DAC_CMD_WRITE_UPD: AD5683 "write and update DAC register" command
//   - dac_frame()      : assembles {cmd, code, 4'b0} into one SPI frame
// ---------------------------------------------------------------------------
package dac_pkg;

  localparam int FRAME_W   = 24;
  localparam int CODE_W    = 16;
  localparam int BIT_CNT_W = 5;

  localparam logic [3:0] DAC_CMD_WRITE_UPD = 4'h3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    SHIFT  = 3'd2,
    TRAIL  = 3'd3,
    SETTLE = 3'd4
  } dac_state_t;

  // The 4 LSBs are don't-care for a 16-bit AD5683 and are sent as zero.
  function automatic logic [FRAME_W-1:0] dac_frame(input logic [3:0]        cmd,
                                                   input logic [CODE_W-1:0] code);
    return {cmd, code, 4'b0000};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// ---------------------------------------------------------------------------
// spi_tick_gen
//   Free-running down-counter that marks the last clk_i cycle of every
//   SCLK half-period. Restart reloads the counter so the next phase gets a
//   full CLK_DIV cycles regardless of where the counter was.
// Ports
//   clk_i    in  1  system clock
//   arst_ni  in  1  asynchronous active-low reset
//   restart  in  1  synchronous reload to CLK_DIV-1
//   tick     out 1  1 on the final cycle of the current half-period
// ---------------------------------------------------------------------------
module spi_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic restart,
  output logic tick
);

  // A 1-cycle divider still needs a 1-bit counter to exist; it just stays at 0.
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q <= RELOAD;
    end else if (restart || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/dac_spi_writer.sv
// ---------------------------------------------------------------------------
// dac_spi_writer
//   Receives 16-bit threshold codes from the channel measure controller and
//   shifts each one out as a 24-bit AD5683-style SPI frame to the comparator
//   reference DAC. threshold_rdy_o stays low until the frame has been sent
//   and the DAC output has had SETTLE_CYCLES to settle. Writes that arrive
//   while busy land in a single pending slot (last write wins) and are sent
//   back-to-back without passing through IDLE.
// Parameters
//   CLK_DIV        clk_i cycles per SCLK half-period (>=1)
//   SETTLE_CYCLES  clk_i cycles with SYNC high before ready returns (>=1)
//   DAC_CMD        4-bit command prefix of every frame
// Ports
//   clk_i            in  1   system clock
//   arst_ni          in  1   asynchronous active-low reset
//   threshold_i      in  16  threshold code, sampled on threshold_wre_i
//   threshold_wre_i  in  1   single-cycle write strobe
//   threshold_rdy_o  out 1   idle, nothing pending, DAC settled
//   dac_sclk_o       out 1   SPI clock, idle low
//   dac_sync_no      out 1   SPI frame select, active-low
//   dac_sdi_o        out 1   SPI data, MSB first, stable across SCLK fall
//   busy_o           out 1   frame or settle in progress
// ---------------------------------------------------------------------------
module dac_spi_writer
  import dac_pkg::*;
#(
  parameter int         CLK_DIV       = 2,
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] DAC_CMD       = DAC_CMD_WRITE_UPD
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic [CODE_W-1:0] threshold_i,
  input  logic              threshold_wre_i,
  output logic              threshold_rdy_o,
  output logic              dac_sclk_o,
  output logic              dac_sync_no,
  output logic              dac_sdi_o,
  output logic              busy_o
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0]     SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_TOP     = BIT_CNT_W'(FRAME_W - 1);

  // Control state
  dac_state_t           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 hi_q, hi_d;          // current SHIFT half is the SCLK-high half
  logic [SET_W-1:0]     settle_q, settle_d;
  logic                 pend_vld_q, pend_vld_d;

  // Data state (no reset: only meaningful while the matching control flag is set)
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [CODE_W-1:0]    pend_word_q, pend_word_d;

  // Registered outputs and their next values
  logic rdy_q, rdy_d;
  logic busy_q, busy_d;
  logic sclk_q, sclk_d;
  logic sync_n_q, sync_n_d;
  logic sdi_q, sdi_d;

  logic tick;
  logic tick_restart;
  logic settle_exit;
  logic in_frame_d;

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .restart (tick_restart),
    .tick    (tick)
  );

  assign settle_exit = (state_q == SETTLE) && (settle_q == '0);

  // State register; outputs are registered from their next-state decode so
  // they change on the same edge as the state they describe.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      hi_q       <= 1'b0;
      settle_q   <= '0;
      pend_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      sync_n_q   <= 1'b1;
      sdi_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      hi_q       <= hi_d;
      settle_q   <= settle_d;
      pend_vld_q <= pend_vld_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      sync_n_q   <= sync_n_d;
      sdi_q      <= sdi_d;
    end
  end

  always_ff @(posedge clk_i) begin
    shreg_q     <= shreg_d;
    pend_word_q <= pend_word_d;
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    hi_d         = hi_q;
    settle_d     = settle_q;
    pend_vld_d   = pend_vld_q;
    pend_word_d  = pend_word_q;
    shreg_d      = shreg_q;
    tick_restart = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Hold the divider in reload so LEAD gets exactly CLK_DIV cycles.
        tick_restart = 1'b1;
        if (threshold_wre_i) begin
          state_d = LEAD;
          shreg_d = dac_frame(DAC_CMD, threshold_i);
        end
      end

      LEAD: begin
        if (tick) begin
          state_d   = SHIFT;
          hi_d      = 1'b1;
          bit_cnt_d = BIT_TOP;
        end
      end

      SHIFT: begin
        if (tick) begin
          if (hi_q) begin
            hi_d = 1'b0;
          end else if (bit_cnt_q == '0) begin
            state_d = TRAIL;
          end else begin
            // Next bit goes out together with the SCLK rise, so SDI is
            // stable for the whole high phase and across the falling edge.
            hi_d      = 1'b1;
            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
            shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
          end
        end
      end

      TRAIL: begin
        if (tick) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end

      SETTLE: begin
        tick_restart = 1'b1;
        if (settle_exit) begin
          // A write landing on the exit cycle is newer than any pending word.
          if (threshold_wre_i || pend_vld_q) begin
            state_d    = LEAD;
            shreg_d    = dac_frame(DAC_CMD, threshold_wre_i ? threshold_i : pend_word_q);
            pend_vld_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Writes while busy only touch the pending slot; the in-flight frame is untouched.
    if (threshold_wre_i && (state_q != IDLE) && !settle_exit) begin
      pend_vld_d  = 1'b1;
      pend_word_d = threshold_i;
    end
  end

  // Output decode of the next state
  always_comb begin
    in_frame_d = (state_d == LEAD) || (state_d == SHIFT) || (state_d == TRAIL);
    rdy_d      = (state_d == IDLE) && !pend_vld_d;
    busy_d     = (state_d != IDLE);
    sync_n_d   = !in_frame_d;
    sclk_d     = (state_d == SHIFT) && hi_d;
    sdi_d      = in_frame_d && shreg_d[FRAME_W-1];
  end

  assign threshold_rdy_o = rdy_q;
  assign busy_o          = busy_q;
  assign dac_sclk_o      = sclk_q;
  assign dac_sync_no     = sync_n_q;
  assign dac_sdi_o       = sdi_q;

endmodule

// File: tb/tb_dac_spi_writer.sv
module tb_dac_spi_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: default parameters; DUT 1: CLK_DIV=1, SETTLE_CYCLES=1
  logic        arst_n0, wre0, rdy0, sclk0, sync0, sdi0, busy0;
  logic        arst_n1, wre1, rdy1, sclk1, sync1, sdi1, busy1;
  logic [15:0] thr0, thr1;

  dac_spi_writer u_dut_def (
    .clk_i           (clk),
    .arst_ni         (arst_n0),
    .threshold_i     (thr0),
    .threshold_wre_i (wre0),
    .threshold_rdy_o (rdy0),
    .dac_sclk_o      (sclk0),
    .dac_sync_no     (sync0),
    .dac_sdi_o       (sdi0),
    .busy_o          (busy0)
  );

  dac_spi_writer #(
    .CLK_DIV       (1),
    .SETTLE_CYCLES (1)
  ) u_dut_fast (
    .clk_i           (clk),
    .arst_ni         (arst_n1),
    .threshold_i     (thr1),
    .threshold_wre_i (wre1),
    .threshold_rdy_o (rdy1),
    .dac_sclk_o      (sclk1),
    .dac_sync_no     (sync1),
    .dac_sdi_o       (sdi1),
    .busy_o          (busy1)
  );

  // ---------------- SPI frame monitor ----------------
  typedef struct {
    logic [23:0] bits;
    int          rises;
    int          hi;
    int          low;
    int          gap;
  } frame_t;

  frame_t fq0[$];
  frame_t fq1[$];
  frame_t cur[2];
  int     gap_cnt[2]  = '{0, 0};
  int     sdi_viol[2] = '{0, 0};
  logic   p_sclk[2]   = '{1'b0, 1'b0};
  logic   p_sync[2]   = '{1'b1, 1'b1};
  logic   p_sdi[2]    = '{1'b0, 1'b0};

  task automatic mon(input int d, input logic sclk, input logic sync_n, input logic sdi);
    if (sync_n === 1'b0) begin
      if (p_sync[d] === 1'b1) cur[d] = '{24'h0, 0, 0, 0, gap_cnt[d]};
      cur[d].low++;
      if (sclk === 1'b1) cur[d].hi++;
      if (sclk === 1'b1 && p_sclk[d] === 1'b0) cur[d].rises++;
      if (sclk === 1'b0 && p_sclk[d] === 1'b1) cur[d].bits = {cur[d].bits[22:0], sdi};
      if (p_sync[d] === 1'b0 && sdi !== p_sdi[d] && !(sclk === 1'b1 && p_sclk[d] === 1'b0))
        sdi_viol[d]++;
    end else begin
      if (p_sync[d] === 1'b0) begin
        if (d == 0) fq0.push_back(cur[d]);
        else        fq1.push_back(cur[d]);
        gap_cnt[d] = 0;
      end
      gap_cnt[d]++;
    end
    p_sclk[d] = sclk;
    p_sync[d] = sync_n;
    p_sdi[d]  = sdi;
  endtask

  always @(negedge clk) mon(0, sclk0, sync0, sdi0);
  always @(negedge clk) mon(1, sclk1, sync1, sdi1);

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: pulse wre for one cycle and count edges until rdy rises.
  task automatic send(input int d, input logic [15:0] w, input int max, output int lat);
    if (d == 0) begin thr0 = w; wre0 = 1'b1; end
    else        begin thr1 = w; wre1 = 1'b1; end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      wre0 = 1'b0;
      wre1 = 1'b0;
    end while ((((d == 0) ? rdy0 : rdy1) !== 1'b1) && (lat < max));
  endtask

  typedef struct {
    logic [15:0] word;
    logic [23:0] frame;
  } vec_t;

  vec_t        vt[4];
  logic [15:0] w5[3];
  frame_t      f;
  int          lat;
  int          bad;
  int          cyc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{16'hA55A, 24'h3A55A0};
    vt[1] = '{16'h0000, 24'h300000};
    vt[2] = '{16'hFFFF, 24'h3FFFF0};
    vt[3] = '{16'h1234, 24'h312340};
    w5[0] = 16'hC3C3;
    w5[1] = 16'h5A5A;
    w5[2] = 16'h0F0F;

    wre0 = 1'b0; wre1 = 1'b0; thr0 = '0; thr1 = '0;
    arst_n0 = 1'b1; arst_n1 = 1'b1;
    #2;
    arst_n0 = 1'b0; arst_n1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rdy",    {31'b0, rdy0},  1);
    check("reset sync_n", {31'b0, sync0}, 1);
    check("reset sclk",   {31'b0, sclk0}, 0);
    check("reset sdi",    {31'b0, sdi0},  0);
    check("reset busy",   {31'b0, busy0}, 0);
    arst_n0 = 1'b1; arst_n1 = 1'b1;

    // Idle hold after reset release
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({rdy0, sync0, sclk0, sdi0, busy0} !== 5'b11000) bad++;
    end
    check("idle hold bad cycles", bad, 0);

    // Single frames at default parameters
    for (int i = 0; i < 4; i++) begin
      fq0.delete();
      send(0, vt[i].word, 300, lat);
      check($sformatf("vec%0d latency", i), lat, 105);
      check($sformatf("vec%0d frame count", i), fq0.size(), 1);
      if (fq0.size() > 0) begin
        f = fq0.pop_front();
        check($sformatf("vec%0d sdi bits", i), {8'h0, f.bits}, {8'h0, vt[i].frame});
        check($sformatf("vec%0d sclk rises", i), f.rises, 24);
        check($sformatf("vec%0d sclk high cycles", i), f.hi, 48);
        check($sformatf("vec%0d sync_n low cycles", i), f.low, 100);
      end
      @(negedge clk);
    end

    // Writes during a frame: only the last one is sent, rdy stays low throughout
    fq0.delete();
    thr0 = 16'h0001; wre0 = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      wre0 = 1'b0;
      if (lat == 20) begin thr0 = 16'h1111; wre0 = 1'b1; end
      if (lat == 40) begin thr0 = 16'h2222; wre0 = 1'b1; end
    end while (rdy0 !== 1'b1 && lat < 500);
    check("pending rdy latency", lat, 209);
    check("pending frame count", fq0.size(), 2);
    if (fq0.size() == 2) begin
      check("pending frame0", {8'h0, fq0[0].bits}, 32'h00300010);
      check("pending frame1", {8'h0, fq0[1].bits}, 32'h00322220);
      check("pending frame1 gap", fq0[1].gap, 4);
    end
    @(negedge clk);

    // Asynchronous reset in the middle of a frame, with a pending word queued
    thr0 = 16'h4321; wre0 = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      wre0 = 1'b0;
      if (lat == 10) begin thr0 = 16'hDEAD; wre0 = 1'b1; end
    end while (lat < 56);
    check("mid-frame sync_n before reset", {31'b0, sync0}, 0);
    check("mid-frame busy before reset",   {31'b0, busy0}, 1);
    @(posedge clk);
    #1 arst_n0 = 1'b0;
    #1;
    check("async reset sync_n", {31'b0, sync0}, 1);
    check("async reset sclk",   {31'b0, sclk0}, 0);
    check("async reset rdy",    {31'b0, rdy0},  1);
    check("async reset busy",   {31'b0, busy0}, 0);
    check("async reset sdi",    {31'b0, sdi0},  0);
    @(negedge clk);
    arst_n0 = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (sync0 !== 1'b1 || rdy0 !== 1'b1) bad++;
    end
    check("pending cleared by reset", bad, 0);
    fq0.delete();
    send(0, 16'h00FF, 300, lat);
    check("post-reset latency", lat, 105);
    check("post-reset frame count", fq0.size(), 1);
    if (fq0.size() > 0) begin
      f = fq0.pop_front();
      check("post-reset sdi bits", {8'h0, f.bits}, 32'h00300FF0);
      check("post-reset sclk rises", f.rises, 24);
    end

    // Fast instance: each new write lands on the SETTLE exit cycle
    fq1.delete();
    @(negedge clk);
    thr1 = w5[0]; wre1 = 1'b1;
    for (int k = 1; k < 3; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        wre1 = 1'b0;
      end while (!(sync1 === 1'b1 && busy1 === 1'b1) && cyc < 200);
      check($sformatf("fast settle reached %0d", k), {31'b0, (cyc < 200)}, 1);
      thr1 = w5[k]; wre1 = 1'b1;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      wre1 = 1'b0;
    end while (rdy1 !== 1'b1 && lat < 200);
    check("fast last latency", lat, 52);
    check("fast frame count", fq1.size(), 3);
    if (fq1.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("fast frame%0d bits", k), {8'h0, fq1[k].bits}, {8'h0, 4'h3, w5[k], 4'h0});
        check($sformatf("fast frame%0d rises", k), fq1[k].rises, 24);
        check($sformatf("fast frame%0d sclk high", k), fq1[k].hi, 24);
        check($sformatf("fast frame%0d sync_n low", k), fq1[k].low, 50);
        if (k > 0) check($sformatf("fast frame%0d sync_n gap", k), fq1[k].gap, 1);
      end
    end

    check("default sdi changes off sclk rise", sdi_viol[0], 0);
    check("fast sdi changes off sclk rise", sdi_viol[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
